uart_rx_frame_chk: RTL and testbench

Parametrised UART receive frame checker. It is the successor to the single stop-bit checker.
- Takes over frame-level checking after the start bit is validated: data deserialisation, optional parity check, and 1 or 2 stop-bit checks.
- Per-frame error flags, held until the next frame starts.
- Saturating error counters for the register file.
- Sits between the RX bit sampler and the RX output/sync stage.

---
 rtl/uart_rx_frame_chk.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_frame_chk.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_chk.sv
// UART receive frame checker: deserialises the data bits that follow a
// validated start bit, then checks the optional parity bit and one or two
// stop bits. Each finished frame reports per-frame error flags, and two
// saturating counters accumulate parity and stop errors.
module uart_rx_frame_chk #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  bit_valid,
    input  logic                  sampled_bit,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stop_bits,
    input  logic                  err_clr,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_done,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stop_err_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP1  = 3'd3,
        STOP2  = 3'd4
    } state_t;

    localparam int                   BCW      = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0]       LAST_BIT = BCW'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    // Expected parity bit: even parity makes the total number of ones even,
    // odd parity inverts that.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d,
                                         input logic odd);
        return (^d) ^ odd;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_WIDTH'(1);
    endfunction

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [DATA_WIDTH-1:0]   shift_r;
    logic [BCW-1:0]          bit_cnt_r;
    logic                    cfg_par_en_r;
    logic                    cfg_par_typ_r;
    logic                    cfg_stop_bits_r;
    logic                    perr_r;
    logic                    serr_r;

    logic                    start_s;
    logic                    shift_en_s;
    logic                    finish_s;
    logic                    perr_set_s;
    logic                    serr_set_s;
    logic                    serr_fin_s;

    assign busy = (state_r != IDLE);

    // Next-state and per-cycle control decode from the registered state.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        shift_en_s  = 1'b0;
        finish_s    = 1'b0;
        perr_set_s  = 1'b0;
        serr_set_s  = 1'b0;
        case (state_r)
            IDLE: begin
                // bit_valid is ignored here, including when it coincides
                // with frame_start.
                if (frame_start) begin
                    start_s     = 1'b1;
                    state_nxt_s = DATA;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DATA: begin
                if (bit_valid) begin
                    shift_en_s = 1'b1;
                    if (bit_cnt_r == LAST_BIT) begin
                        state_nxt_s = cfg_par_en_r ? PARITY : STOP1;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    state_nxt_s = DATA;
                end
            end
            PARITY: begin
                if (bit_valid) begin
                    perr_set_s  = (sampled_bit != calc_parity(shift_r, cfg_par_typ_r));
                    state_nxt_s = STOP1;
                end else begin
                    state_nxt_s = PARITY;
                end
            end
            STOP1: begin
                if (bit_valid) begin
                    if (!sampled_bit) begin
                        // A bad first stop bit ends the frame even when a
                        // second stop bit was configured.
                        serr_set_s  = 1'b1;
                        finish_s    = 1'b1;
                        state_nxt_s = IDLE;
                    end else if (cfg_stop_bits_r) begin
                        state_nxt_s = STOP2;
                    end else begin
                        finish_s    = 1'b1;
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = STOP1;
                end
            end
            STOP2: begin
                if (bit_valid) begin
                    serr_set_s  = ~sampled_bit;
                    finish_s    = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = STOP2;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Stop error as seen on the finishing edge, including the bit consumed now.
    assign serr_fin_s = serr_r | serr_set_s;

    // State register, datapath, frame results and error counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r         <= IDLE;
            shift_r         <= '0;
            bit_cnt_r       <= '0;
            cfg_par_en_r    <= 1'b0;
            cfg_par_typ_r   <= 1'b0;
            cfg_stop_bits_r <= 1'b0;
            perr_r          <= 1'b0;
            serr_r          <= 1'b0;
            data_out        <= '0;
            data_valid      <= 1'b0;
            frame_done      <= 1'b0;
            parity_error    <= 1'b0;
            stop_error      <= 1'b0;
            par_err_cnt     <= '0;
            stop_err_cnt    <= '0;
        end else begin
            state_r    <= state_nxt_s;
            frame_done <= finish_s;
            data_valid <= finish_s & ~perr_r & ~serr_fin_s;

            if (start_s) begin
                bit_cnt_r       <= '0;
                cfg_par_en_r    <= par_en;
                cfg_par_typ_r   <= par_typ;
                cfg_stop_bits_r <= stop_bits;
                perr_r          <= 1'b0;
                serr_r          <= 1'b0;
                parity_error    <= 1'b0;
                stop_error      <= 1'b0;
            end

            if (shift_en_s) begin
                shift_r   <= {sampled_bit, shift_r[DATA_WIDTH-1:1]};
                bit_cnt_r <= bit_cnt_r + BCW'(1);
            end

            if (perr_set_s) begin
                perr_r <= 1'b1;
            end

            if (serr_set_s) begin
                serr_r <= 1'b1;
            end

            if (finish_s) begin
                parity_error <= perr_r;
                stop_error   <= serr_fin_s;
                if (!perr_r && !serr_fin_s) begin
                    data_out <= shift_r;
                end
            end

            // A clear always beats a coincident increment.
            if (err_clr) begin
                par_err_cnt  <= '0;
                stop_err_cnt <= '0;
            end else if (finish_s) begin
                if (perr_r) begin
                    par_err_cnt <= sat_inc(par_err_cnt);
                end
                if (serr_fin_s) begin
                    stop_err_cnt <= sat_inc(stop_err_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// Directed testbench for uart_rx_frame_chk (DATA_WIDTH=8, CNT_WIDTH=2).
module tb_uart_rx_frame_chk;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_start = 1'b0;
    logic       bit_valid = 1'b0;
    logic       sampled_bit = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       stop_bits = 1'b0;
    logic       err_clr = 1'b0;
    logic       busy;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_done;
    logic       parity_error;
    logic       stop_error;
    logic [1:0] par_err_cnt;
    logic [1:0] stop_err_cnt;

    int checks = 0;
    int failures = 0;

    uart_rx_frame_chk #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .bit_valid(bit_valid),
        .sampled_bit(sampled_bit), .par_en(par_en), .par_typ(par_typ),
        .stop_bits(stop_bits), .err_clr(err_clr), .busy(busy),
        .data_out(data_out), .data_valid(data_valid), .frame_done(frame_done),
        .parity_error(parity_error), .stop_error(stop_error),
        .par_err_cnt(par_err_cnt), .stop_err_cnt(stop_err_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then stable for sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse frame_start with a configuration, then scramble the config pins.
    task automatic start_frame(input logic pe, input logic pt, input logic sb);
        par_en = pe; par_typ = pt; stop_bits = sb;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        par_en = ~pe; par_typ = ~pt; stop_bits = ~sb;
    endtask

    // One idle cycle, then one bit_valid pulse (optionally with err_clr).
    task automatic send_bit(input logic b, input logic clr);
        tick();
        sampled_bit = b; bit_valid = 1'b1; err_clr = clr;
        tick();
        bit_valid = 1'b0; err_clr = 1'b0;
    endtask

    // Data LSB first, optional parity, first stop bit, optional second stop bit.
    task automatic send_body(input logic [7:0] d, input logic pe, input logic pbit,
                             input logic s1, input logic two, input logic s2,
                             input logic clr_last);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
        if (pe) send_bit(pbit, 1'b0);
        if (two) begin
            send_bit(s1, 1'b0);
            send_bit(s2, clr_last);
        end else begin
            send_bit(s1, clr_last);
        end
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        checks++;
        if ({busy, data_out, data_valid, frame_done, parity_error, stop_error,
             par_err_cnt, stop_err_cnt} !== 17'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%0b data=%h dv=%0b fd=%0b pe=%0b se=%0b pc=%0d sc=%0d want all 0",
                     busy, data_out, data_valid, frame_done, parity_error, stop_error, par_err_cnt, stop_err_cnt);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_good_frame();
        start_frame(1'b1, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL good_busy: got %0b want 1", busy); end
        send_body(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({frame_done, data_valid, data_out, parity_error, stop_error, par_err_cnt, stop_err_cnt, busy}
            !== {1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0}) begin
            failures++;
            $display("FAIL good_result: got fd=%0b dv=%0b data=%h pe=%0b se=%0b pc=%0d sc=%0d busy=%0b want 1 1 a5 0 0 0 0 0",
                     frame_done, data_valid, data_out, parity_error, stop_error, par_err_cnt, stop_err_cnt, busy);
        end
        tick();
        checks++;
        if ({frame_done, data_valid} !== 2'b00) begin
            failures++; $display("FAIL good_pulse: got fd=%0b dv=%0b want 0 0", frame_done, data_valid);
        end
    endtask

    task automatic test_parity_error();
        start_frame(1'b1, 1'b0, 1'b0);
        send_body(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({frame_done, data_valid, parity_error, stop_error, par_err_cnt, stop_err_cnt}
            !== {1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0}) begin
            failures++;
            $display("FAIL perr_result: got fd=%0b dv=%0b pe=%0b se=%0b pc=%0d sc=%0d want 1 0 1 0 1 0",
                     frame_done, data_valid, parity_error, stop_error, par_err_cnt, stop_err_cnt);
        end
        tick(); tick(); tick();
        checks++;
        if (parity_error !== 1'b1) begin failures++; $display("FAIL perr_hold: got %0b want 1", parity_error); end
        start_frame(1'b1, 1'b0, 1'b0);
        checks++;
        if (parity_error !== 1'b0) begin failures++; $display("FAIL perr_clear_on_start: got %0b want 0", parity_error); end
        send_body(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({data_valid, data_out, par_err_cnt} !== {1'b1, 8'hA5, 2'd1}) begin
            failures++; $display("FAIL perr_recover: got dv=%0b data=%h pc=%0d want 1 a5 1", data_valid, data_out, par_err_cnt);
        end
    endtask

    task automatic test_stop_error();
        pulse_clr();
        start_frame(1'b0, 1'b0, 1'b1);
        send_body(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({frame_done, data_valid, data_out, parity_error, stop_error, par_err_cnt, stop_err_cnt}
            !== {1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 2'd0, 2'd1}) begin
            failures++;
            $display("FAIL serr_result: got fd=%0b dv=%0b data=%h pe=%0b se=%0b pc=%0d sc=%0d want 1 0 a5 0 1 0 1",
                     frame_done, data_valid, data_out, parity_error, stop_error, par_err_cnt, stop_err_cnt);
        end
    endtask

    task automatic test_early_stop();
        start_frame(1'b0, 1'b0, 1'b1);
        send_body(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({frame_done, busy, stop_error, stop_err_cnt} !== {1'b1, 1'b0, 1'b1, 2'd2}) begin
            failures++;
            $display("FAIL early_stop_end: got fd=%0b busy=%0b se=%0b sc=%0d want 1 0 1 2",
                     frame_done, busy, stop_error, stop_err_cnt);
        end
        send_bit(1'b0, 1'b0);
        checks++;
        if ({frame_done, busy, stop_err_cnt} !== {1'b0, 1'b0, 2'd2}) begin
            failures++;
            $display("FAIL early_stop_idle: got fd=%0b busy=%0b sc=%0d want 0 0 2", frame_done, busy, stop_err_cnt);
        end
    endtask

    task automatic test_odd_parity();
        start_frame(1'b1, 1'b1, 1'b1);
        send_body(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({frame_done, data_valid, data_out, parity_error, stop_error}
            !== {1'b1, 1'b1, 8'h3C, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL odd_par_result: got fd=%0b dv=%0b data=%h pe=%0b se=%0b want 1 1 3c 0 0",
                     frame_done, data_valid, data_out, parity_error, stop_error);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        pulse_clr();
        for (int n = 1; n <= 5; n++) begin
            start_frame(1'b1, 1'b0, 1'b0);
            send_body(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            exp_cnt = (n >= 3) ? 2'd3 : 2'(n);
            checks++;
            if ({par_err_cnt, data_out} !== {exp_cnt, 8'h3C}) begin
                failures++;
                $display("FAIL sat_count_%0d: got pc=%0d data=%h want %0d 3c", n, par_err_cnt, data_out, exp_cnt);
            end
        end
        start_frame(1'b1, 1'b0, 1'b0);
        send_body(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({frame_done, parity_error, par_err_cnt, stop_err_cnt} !== {1'b1, 1'b1, 2'd0, 2'd0}) begin
            failures++;
            $display("FAIL sat_clear_wins: got fd=%0b pe=%0b pc=%0d sc=%0d want 1 1 0 0",
                     frame_done, parity_error, par_err_cnt, stop_err_cnt);
        end
    endtask

    task automatic test_start_ignored();
        logic [7:0] d;
        d = 8'h96;
        start_frame(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                frame_start = 1'b1;
                tick();
                frame_start = 1'b0;
            end
            send_bit(d[i], 1'b0);
        end
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        checks++;
        if ({frame_done, data_valid, data_out, busy} !== {1'b1, 1'b1, 8'h96, 1'b0}) begin
            failures++;
            $display("FAIL start_ignored: got fd=%0b dv=%0b data=%h busy=%0b want 1 1 96 0",
                     frame_done, data_valid, data_out, busy);
        end
    endtask

    task automatic test_back_to_back();
        start_frame(1'b0, 1'b0, 1'b0);
        send_body(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({frame_done, stop_error, stop_err_cnt} !== {1'b1, 1'b1, 2'd1}) begin
            failures++;
            $display("FAIL b2b_first: got fd=%0b se=%0b sc=%0d want 1 1 1", frame_done, stop_error, stop_err_cnt);
        end
        start_frame(1'b0, 1'b0, 1'b0);
        checks++;
        if ({busy, stop_error, frame_done} !== 3'b100) begin
            failures++;
            $display("FAIL b2b_start: got busy=%0b se=%0b fd=%0b want 1 0 0", busy, stop_error, frame_done);
        end
        send_body(8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({frame_done, data_valid, data_out} !== {1'b1, 1'b1, 8'h7E}) begin
            failures++;
            $display("FAIL b2b_second: got fd=%0b dv=%0b data=%h want 1 1 7e", frame_done, data_valid, data_out);
        end
    endtask

    task automatic test_reset_mid_frame();
        start_frame(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        rst = 1'b0;
        tick();
        checks++;
        if ({busy, data_out, data_valid, frame_done, parity_error, stop_error,
             par_err_cnt, stop_err_cnt} !== 17'd0) begin
            failures++;
            $display("FAIL mid_reset: got busy=%0b data=%h dv=%0b fd=%0b pe=%0b se=%0b pc=%0d sc=%0d want all 0",
                     busy, data_out, data_valid, frame_done, parity_error, stop_error, par_err_cnt, stop_err_cnt);
        end
        rst = 1'b1;
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0);
        checks++;
        if ({busy, frame_done} !== 2'b00) begin
            failures++; $display("FAIL mid_reset_abandon: got busy=%0b fd=%0b want 0 0", busy, frame_done);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_error();
        test_stop_error();
        test_early_stop();
        test_odd_parity();
        test_saturation();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
